// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state type, sampling offsets and parity encodings for the UART receiver
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } uart_rx_state_t;

  localparam int SMP_OFS_LO = -1;
  localparam int SMP_OFS_HI = 1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchroniser and 3-sample majority vote around mid-bit
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] half,
  output logic                  rx_s,
  output logic                  vote,
  output logic                  vote_valid
);

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= (sync_q << 1) | SYNC_STAGES'(rx_in);
      end
      assign rx_s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign rx_s = rx_in;
    end
  endgenerate

  logic [PRESCALE_W-1:0] idx_lo;
  logic [PRESCALE_W-1:0] idx_hi;
  logic                  s_lo;
  logic                  s_mid;

  assign idx_lo = PRESCALE_W'(int'(half) + SMP_OFS_LO);
  assign idx_hi = PRESCALE_W'(int'(half) + SMP_OFS_HI);

  // third sample feeds the vote directly, so the result lands one cycle after it
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_lo       <= 1'b1;
      s_mid      <= 1'b1;
      vote       <= 1'b1;
      vote_valid <= 1'b0;
    end else begin
      vote_valid <= 1'b0;
      if (en) begin
        if (edge_cnt == idx_lo) s_lo <= rx_s;
        if (edge_cnt == half)   s_mid <= rx_s;
        if (edge_cnt == idx_hi) begin
          vote       <= maj3(s_lo, s_mid, rx_s);
          vote_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver: frame FSM, bit counters, shift register, parity/stop checks
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PRESCALE_W  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  stop2,
  output logic [DATA_W-1:0]     p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  uart_rx_state_t        state, state_nxt;
  logic [PRESCALE_W-1:0] edge_cnt, prescale_q, half;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_W-1:0]     shreg;
  logic                  par_en_q, par_type_q, stop2_q;
  logic                  par_bad, stp_bad, armed;
  logic                  rx_s, vote, vote_valid;
  logic                  start_det, wrap, last_bit;
  logic                  done, done_par, done_stp;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .en        (state != IDLE),
    .edge_cnt  (edge_cnt),
    .half      (half),
    .rx_s      (rx_s),
    .vote      (vote),
    .vote_valid(vote_valid)
  );

  assign half      = prescale_q >> 1;
  assign wrap      = (edge_cnt == prescale_q - PRESCALE_W'(1));
  assign last_bit  = (bit_cnt == BIT_W'(DATA_W - 1));
  // armed blocks re-triggering on a held-low line after a break
  assign start_det = (state == IDLE) && armed && !rx_s;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    done_par  = par_bad;
    done_stp  = stp_bad;
    case (state)
      IDLE:   if (start_det) state_nxt = START;
      START:  if (vote_valid && vote) state_nxt = IDLE;
              else if (wrap) state_nxt = DATA;
      DATA:   if (wrap && last_bit) state_nxt = par_en_q ? PARITY : STOP1;
      PARITY: if (wrap) state_nxt = STOP1;
      STOP1:  if (vote_valid && !stop2_q) begin
                done      = 1'b1;
                state_nxt = IDLE;
              end else if (wrap && stop2_q) begin
                state_nxt = STOP2;
              end
      STOP2:  if (vote_valid) begin
                done      = 1'b1;
                state_nxt = IDLE;
              end
      default: state_nxt = IDLE;
    endcase
    if (done && !vote) done_stp = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= PAR_EVEN;
      stop2_q    <= 1'b0;
      par_bad    <= 1'b0;
      stp_bad    <= 1'b0;
      armed      <= 1'b1;
    end else begin
      state      <= state_nxt;
      data_valid <= done && !done_par && !done_stp;
      par_err    <= done && done_par;
      stp_err    <= done && done_stp;
      if (done && !done_par && !done_stp) p_data <= shreg;

      if (state == IDLE) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
        if (rx_s) armed <= 1'b1;
        if (start_det) begin
          prescale_q <= prescale;
          par_en_q   <= par_en;
          par_type_q <= par_type ? PAR_ODD : PAR_EVEN;
          stop2_q    <= stop2;
          par_bad    <= 1'b0;
          stp_bad    <= 1'b0;
        end
      end else begin
        edge_cnt <= wrap ? '0 : edge_cnt + PRESCALE_W'(1);
        if (state == DATA && wrap) bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
        if (vote_valid) begin
          case (state)
            DATA:         shreg <= {vote, shreg[DATA_W-1:1]};
            PARITY:       par_bad <= (vote != ((^shreg) ^ (par_type_q == PAR_ODD)));
            STOP1, STOP2: if (!vote) stp_bad <= 1'b1;
            default:      ;
          endcase
        end
      end

      if (done && done_stp) armed <= 1'b0;
    end
  end

endmodule
